window_gen: RTL

WINDOW_GEN -- requirements
Module: window_gen

---
 rtl/window_gen_pkg.sv | 8 +
 rtl/window_gen_line_buffer.sv | 25 ++
 rtl/window_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/window_gen_pkg.sv
// Shared constants for the 3x3 window generator.
// Holds the default image geometry and the kernel size.
package window_gen_pkg;
    localparam int DWIDTH_DEF     = 16;
    localparam int IMG_WIDTH_DEF  = 28;
    localparam int IMG_HEIGHT_DEF = 28;
    localparam int KSIZE          = 3;
endpackage

// File: rtl/window_gen_line_buffer.sv
// Enable-gated shift delay of `depth` accepted samples.
// The output is the sample accepted `depth` enables earlier.
module line_buffer #(
    parameter int dwidth = 16,
    parameter int depth  = 28
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic signed [dwidth-1:0] din,
    output logic signed [dwidth-1:0] dout
);
    logic signed [dwidth-1:0] taps [depth];

    // Contents are never reset; window gating keeps stale data from being flagged valid.
    always_ff @(posedge clk) begin
        if (en) begin
            taps[0] <= din;
            for (int i = 1; i < depth; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    assign dout = taps[depth-1];
endmodule

// File: rtl/window_gen.sv
// Converts a raster pixel stream into 3x3 sliding windows.
// win22 is the newest pixel; win00 is two rows up and two columns left.
module window_gen
    import window_gen_pkg::*;
#(
    parameter int dwidth     = DWIDTH_DEF,
    parameter int img_width  = IMG_WIDTH_DEF,
    parameter int img_height = IMG_HEIGHT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    input  logic signed [dwidth-1:0] din,
    output logic signed [dwidth-1:0] win00,
    output logic signed [dwidth-1:0] win01,
    output logic signed [dwidth-1:0] win02,
    output logic signed [dwidth-1:0] win10,
    output logic signed [dwidth-1:0] win11,
    output logic signed [dwidth-1:0] win12,
    output logic signed [dwidth-1:0] win20,
    output logic signed [dwidth-1:0] win21,
    output logic signed [dwidth-1:0] win22,
    output logic                     dout_valid,
    output logic                     frame_done
);
    localparam int CW = $clog2(img_width + 1);
    localparam int RW = $clog2(img_height + 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          last_col;
    logic          last_row;
    logic          vld_p0;
    logic          done_p0;
    logic signed [dwidth-1:0] lb1_out;
    logic signed [dwidth-1:0] lb2_out;
    logic signed [dwidth-1:0] win_p0 [KSIZE][KSIZE];

    assign accept   = din_valid && !rst;
    assign last_col = (col == CW'(img_width - 1));
    assign last_row = (row == RW'(img_height - 1));

    line_buffer #(.dwidth(dwidth), .depth(img_width)) u_lb1 (
        .clk  (clk),
        .en   (accept),
        .din  (din),
        .dout (lb1_out)
    );

    line_buffer #(.dwidth(dwidth), .depth(img_width)) u_lb2 (
        .clk  (clk),
        .en   (accept),
        .din  (lb1_out),
        .dout (lb2_out)
    );

    // Stage p0: raster counters, window shift and valid/frame flags
    always_ff @(posedge clk) begin
        if (rst) begin
            col     <= '0;
            row     <= '0;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win_p0[r][c] <= '0;
                end
            end
        end else begin
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            if (din_valid) begin
                // Only windows fully inside one frame and one row are valid.
                vld_p0  <= (row >= RW'(KSIZE - 1)) && (col >= CW'(KSIZE - 1));
                done_p0 <= last_row && last_col;
                if (last_col) begin
                    col <= '0;
                    row <= last_row ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        win_p0[r][c] <= win_p0[r][c+1];
                    end
                end
                win_p0[0][KSIZE-1] <= lb2_out;
                win_p0[1][KSIZE-1] <= lb1_out;
                win_p0[2][KSIZE-1] <= din;
            end
        end
    end

    assign win00      = win_p0[0][0];
    assign win01      = win_p0[0][1];
    assign win02      = win_p0[0][2];
    assign win10      = win_p0[1][0];
    assign win11      = win_p0[1][1];
    assign win12      = win_p0[1][2];
    assign win20      = win_p0[2][0];
    assign win21      = win_p0[2][1];
    assign win22      = win_p0[2][2];
    assign dout_valid = vld_p0;
    assign frame_done = done_p0;
endmodule
